// File: rtl/switch_pio_debounced_if.sv
// Avalon-MM register bus between the Nios data master and the switch PIO.
interface switch_pio_debounced_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata
  );
endinterface

// File: rtl/switch_pio_debounced.sv
// Debounced switch/button PIO: per-bit synchroniser + debounce + edge capture,
// with an interrupt mask and a level irq. Register map on a 2-bit word address.

// One input bit: 2-flop synchroniser, debounce counter and edge event.
module switch_pio_debounced_bit #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_TYPE       = 0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic pin_i,
  output logic sync2_o,
  output logic stable_o,
  output logic event_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  // Two-stage synchroniser for the asynchronous pin.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive samples that disagree with the accepted level;
  // the last one in the run flips the level and restarts the count.
  always_comb begin
    accept   = (sync2_q != stable_q) && (cnt_q == CNT_LAST);
    stable_d = accept ? sync2_q : stable_q;
    cnt_d    = ((sync2_q == stable_q) || accept) ? '0 : cnt_q + CW'(1);
  end

  // Debounce state register; reset discards any partial count.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Event is high in the cycle the level is about to change (old vs new).
  if (EDGE_TYPE == 0) begin : g_rise
    assign event_o = accept & sync2_q;
  end else if (EDGE_TYPE == 1) begin : g_fall
    assign event_o = accept & ~sync2_q;
  end else begin : g_any
    assign event_o = accept;
  end

  assign sync2_o  = sync2_q;
  assign stable_o = stable_q;
endmodule

module switch_pio_debounced #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_TYPE       = 0
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  switch_pio_debounced_if.slave  bus,
  input  logic [WIDTH-1:0]       in_port_i,
  output logic                   irq_o
);
  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_ECAP = 2'd2;
  localparam logic [1:0] A_RAW  = 2'd3;

  logic [WIDTH-1:0] sync2, stable, evt;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             wr_mask, wr_ecap;

  // read is a no-op strobe (readdata is always valid); upper writedata bits
  // beyond WIDTH are ignored.
  logic unused_bus;
  assign unused_bus = &{1'b0, bus.read, bus.writedata};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    switch_pio_debounced_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .EDGE_TYPE       (EDGE_TYPE)
    ) u_bit (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .pin_i    (in_port_i[i]),
      .sync2_o  (sync2[i]),
      .stable_o (stable[i]),
      .event_o  (evt[i])
    );
  end

  assign wr_mask = bus.write && (bus.address == A_MASK);
  assign wr_ecap = bus.write && (bus.address == A_ECAP);

  // Mask write, W1C capture clear; a same-cycle event wins over the clear.
  always_comb begin
    mask_d = wr_mask ? bus.writedata[WIDTH-1:0] : mask_q;
    cap_d  = wr_ecap ? (cap_q & ~bus.writedata[WIDTH-1:0]) : cap_q;
    cap_d  = cap_d | evt;
  end

  // Read mux of current (pre-write) register values, zero-extended.
  always_comb begin
    rdata_d = '0;
    unique case (bus.address)
      A_DATA: rdata_d[WIDTH-1:0] = stable;
      A_MASK: rdata_d[WIDTH-1:0] = mask_q;
      A_ECAP: rdata_d[WIDTH-1:0] = cap_q;
      A_RAW:  rdata_d[WIDTH-1:0] = sync2;
      default: rdata_d = '0;
    endcase
  end

  // Register file and registered read data.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mask_q  <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
    end else begin
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.readdata = rdata_q;
  assign irq_o        = |(cap_q & mask_q);
endmodule

// File: tb/tb_switch_pio_debounced.sv
// Bench for switch_pio_debounced: three instances (rising/falling/any edge)
// share one stimulus stream; a sample-window reference model predicts every
// cycle's readdata and irq.
module tb_switch_pio_debounced;
  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pin = 8'h00;
  logic [1:0]  addr = 2'd0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] wd = 32'h0;
  logic        irq0, irq1, irq2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  switch_pio_debounced_if bus0 ();
  switch_pio_debounced_if bus1 ();
  switch_pio_debounced_if bus2 ();

  assign bus0.address = addr; assign bus0.read = rd; assign bus0.write = wr; assign bus0.writedata = wd;
  assign bus1.address = addr; assign bus1.read = rd; assign bus1.write = wr; assign bus1.writedata = wd;
  assign bus2.address = addr; assign bus2.read = rd; assign bus2.write = wr; assign bus2.writedata = wd;

  switch_pio_debounced #(.WIDTH(8), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(0)) dut0 (
    .clk_i(clk), .reset_i(rst), .bus(bus0), .in_port_i(pin), .irq_o(irq0));
  switch_pio_debounced #(.WIDTH(8), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(1)) dut1 (
    .clk_i(clk), .reset_i(rst), .bus(bus1), .in_port_i(pin), .irq_o(irq1));
  switch_pio_debounced #(.WIDTH(8), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(2)) dut2 (
    .clk_i(clk), .reset_i(rst), .bus(bus2), .in_port_i(pin), .irq_o(irq2));

  // Reference model: the accepted level flips when the current synchronised
  // sample and the previous DC-1 samples all disagree with it.
  logic [7:0]  m_s1, m_s2, m_stable, m_mask;
  logic [7:0]  m_hist [DC-1];
  logic [7:0]  m_cap  [3];
  logic [31:0] m_rd   [3];

  task automatic model_step();
    logic [7:0] flip, nst, clr, val;
    logic [7:0] ev [3];
    if (rst) begin
      m_s1 = 8'h00; m_s2 = 8'h00; m_stable = 8'h00; m_mask = 8'h00;
      for (int j = 0; j < DC-1; j++) m_hist[j] = 8'h00;
      for (int k = 0; k < 3; k++) begin m_cap[k] = 8'h00; m_rd[k] = 32'h0; end
    end else begin
      for (int k = 0; k < 3; k++) begin
        case (addr)
          2'd0: val = m_stable;
          2'd1: val = m_mask;
          2'd2: val = m_cap[k];
          default: val = m_s2;
        endcase
        m_rd[k] = {24'h0, val};
      end
      flip = m_s2 ^ m_stable;
      for (int j = 0; j < DC-1; j++) flip = flip & (m_hist[j] ^ m_stable);
      nst   = m_stable ^ flip;
      ev[0] = flip & nst;
      ev[1] = flip & ~nst;
      ev[2] = flip;
      clr = (wr && addr == 2'd2) ? wd[7:0] : 8'h00;
      for (int k = 0; k < 3; k++) m_cap[k] = (m_cap[k] & ~clr) | ev[k];
      if (wr && addr == 2'd1) m_mask = wd[7:0];
      for (int j = DC-2; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = m_s2;
      m_s2 = m_s1;
      m_s1 = pin;
      m_stable = nst;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rdata_rise", bus0.readdata, m_rd[0]);
    chk("rdata_fall", bus1.readdata, m_rd[1]);
    chk("rdata_any",  bus2.readdata, m_rd[2]);
    chk("irq_rise", {31'h0, irq0}, {31'h0, |(m_cap[0] & m_mask)});
    chk("irq_fall", {31'h0, irq1}, {31'h0, |(m_cap[1] & m_mask)});
    chk("irq_any",  {31'h0, irq2}, {31'h0, |(m_cap[2] & m_mask)});
  endtask

  // One bus cycle: drive at negedge, predict, sample 1 time unit after posedge.
  task automatic cyc(input logic r, input logic [7:0] p, input logic [1:0] a,
                     input logic w, input logic [31:0] d);
    @(negedge clk);
    rst = r; pin = p; addr = a; wr = w; rd = ~w; wd = d;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n, input logic [7:0] p, input logic [1:0] a);
    for (int i = 0; i < n; i++) cyc(1'b0, p, a, 1'b0, 32'h0);
  endtask

  initial begin
    // Reset held with all switches on: everything reads 0.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'hFF, 2'd0, 1'b0, 32'h0);
    chk("reset_rdata", bus0.readdata, 32'h0);
    chk("reset_irq", {31'h0, irq0}, 32'h0);
    // RAW shows the pin two edges after release; DATA after 2+DC.
    idle(3, 8'hFF, 2'd3);
    chk("raw_after_sync", bus0.readdata, 32'h0000_00FF);
    idle(5, 8'hFF, 2'd0);
    chk("data_after_debounce", bus0.readdata, 32'h0000_00FF);

    // Drop everything to 0 and clear any captures.
    idle(8, 8'h00, 2'd0);
    cyc(1'b0, 8'h00, 2'd2, 1'b1, 32'hFFFF_FFFF);

    // 3-cycle glitch on bit0 never reaches DATA or EDGECAP.
    idle(3, 8'h01, 2'd0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 8'h00, 2'd0, 1'b0, 32'h0);
      chk("glitch_data", bus0.readdata, 32'h0);
    end
    idle(2, 8'h00, 2'd2);
    chk("glitch_ecap", bus0.readdata, 32'h0);
    chk("glitch_irq", {31'h0, irq0}, 32'h0);

    // Mask 0x05, rising edges on bits 0 and 2, then W1C each bit.
    cyc(1'b0, 8'h00, 2'd1, 1'b1, 32'hFFFF_FF05);
    idle(8, 8'h05, 2'd2);
    chk("ecap_set", bus0.readdata, 32'h05);
    chk("irq_set", {31'h0, irq0}, 32'h1);
    cyc(1'b0, 8'h05, 2'd2, 1'b1, 32'h01);
    idle(2, 8'h05, 2'd2);
    chk("ecap_w1c_bit0", bus0.readdata, 32'h04);
    chk("irq_still", {31'h0, irq0}, 32'h1);
    cyc(1'b0, 8'h05, 2'd2, 1'b1, 32'h04);
    chk("irq_cleared", {31'h0, irq0}, 32'h0);
    idle(1, 8'h05, 2'd1);
    chk("mask_readback", bus0.readdata, 32'h05);

    // Falling-edge capture: 0x01 -> 0x00 on all three instances.
    idle(8, 8'h01, 2'd0);
    cyc(1'b0, 8'h01, 2'd2, 1'b1, 32'hFF);
    idle(10, 8'h00, 2'd2);
    chk("fall_rise_inst", bus0.readdata, 32'h00);
    chk("fall_fall_inst", bus1.readdata, 32'h01);
    chk("fall_any_inst",  bus2.readdata, 32'h01);
    cyc(1'b0, 8'h00, 2'd2, 1'b1, 32'hFF);

    // W1C of bit1 landing on the very edge its event is captured: set wins.
    idle(DC+1, 8'h02, 2'd0);
    cyc(1'b0, 8'h02, 2'd2, 1'b1, 32'h02);
    idle(2, 8'h02, 2'd2);
    chk("w1c_race_bit1", bus0.readdata & 32'h02, 32'h02);
    cyc(1'b0, 8'h02, 2'd2, 1'b1, 32'h02);
    idle(2, 8'h02, 2'd2);
    chk("w1c_after_race", bus0.readdata & 32'h02, 32'h00);

    // Reset partway through a debounce run discards the count.
    idle(DC+1, 8'h03, 2'd0);
    cyc(1'b1, 8'h03, 2'd0, 1'b0, 32'h0);
    for (int i = 0; i < DC+2; i++) begin
      cyc(1'b0, 8'h03, 2'd0, 1'b0, 32'h0);
      chk("reset_restart_data", bus0.readdata, 32'h0);
    end
    idle(2, 8'h03, 2'd0);
    chk("reset_restart_final", bus0.readdata, 32'h03);

    // Randomised traffic: bursty pin changes, random register accesses, rare resets.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] p;
      logic       r, w;
      p = pin;
      if ($urandom_range(3) == 0) p = pin ^ 8'($urandom);
      r = ($urandom_range(99) == 0);
      w = ($urandom_range(3) == 0);
      cyc(r, p, 2'($urandom_range(3)), w, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
